// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a length-prefixed little-endian word image on rx and writes it to boot memory.
// Optional build macro BOOT_CHECKSUM_EN appends a 32-bit sum check before releasing the CPU.
module uart_boot_loader #(
  parameter int          CLKS_PER_BIT = 217,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          MAX_WORDS    = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data,
  output logic        mem_write,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [31:0]    MAX_W     = 32'(MAX_WORDS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {
    LD_COUNT, LD_DATA, LD_WRITE,
`ifdef BOOT_CHECKSUM_EN
    LD_CHECK,
`endif
    LD_DONE, LD_ERROR
  } ld_state_e;

  logic            rx_meta_q, rx_sync_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid_q, byte_valid_d;
  logic            frame_err_q, frame_err_d;

  ld_state_e       ld_state_q, ld_state_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [23:0]     acc_q, acc_d;
  logic [31:0]     words_left_q, words_left_d;
  logic [31:0]     mem_address_q, mem_address_d;
  logic [31:0]     mem_data_q, mem_data_d;
  logic            mem_write_q, mem_write_d;
  logic            cpu_hold_q, cpu_hold_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic [31:0]     full_word;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0]     sum_q, sum_d;
`endif

  // Middle-of-bit sampling: half a bit after the start edge, then one bit period apart.
  always_comb begin
    rx_state_d   = rx_state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
          clk_cnt_d  = '0;
          bit_cnt_d  = '0;
        end
      end
      RX_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d  = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (clk_cnt_q == FULL_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: begin
        if (clk_cnt_q == FULL_LAST) begin
          clk_cnt_d    = '0;
          byte_valid_d = rx_sync_q;
          frame_err_d  = !rx_sync_q;
          rx_state_d   = RX_IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Bytes arrive LSB-first, so shifting each new byte in from the top leaves a little-endian word.
  assign full_word = {shift_q, acc_q};

  always_comb begin
    ld_state_d    = ld_state_q;
    byte_idx_d    = byte_idx_q;
    acc_d         = acc_q;
    words_left_d  = words_left_q;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    mem_write_d   = 1'b0;
    cpu_hold_d    = cpu_hold_q;
    done_d        = done_q;
    error_d       = error_q;
`ifdef BOOT_CHECKSUM_EN
    sum_d         = sum_q;
`endif
    case (ld_state_q)
      LD_COUNT: begin
        if (byte_valid_q) begin
          byte_idx_d = byte_idx_q + 1'b1;
          acc_d      = {shift_q, acc_q[23:8]};
          if (byte_idx_q == 2'd3) begin
            words_left_d = full_word;
            if (full_word == 32'd0) begin
`ifdef BOOT_CHECKSUM_EN
              ld_state_d = LD_CHECK;
`else
              ld_state_d = LD_DONE;
              done_d     = 1'b1;
              cpu_hold_d = 1'b0;
`endif
            end else if (full_word > MAX_W) begin
              ld_state_d = LD_ERROR;
              error_d    = 1'b1;
            end else begin
              ld_state_d = LD_DATA;
            end
          end
        end
      end
      LD_DATA: begin
        if (byte_valid_q) begin
          byte_idx_d = byte_idx_q + 1'b1;
          mem_data_d = {shift_q, mem_data_q[31:8]};
          if (byte_idx_q == 2'd3) begin
            ld_state_d  = LD_WRITE;
            mem_write_d = 1'b1;
          end
        end
      end
      LD_WRITE: begin
        mem_address_d = mem_address_q + 32'd4;
        words_left_d  = words_left_q - 32'd1;
`ifdef BOOT_CHECKSUM_EN
        sum_d         = sum_q + mem_data_q;
`endif
        if (words_left_q == 32'd1) begin
`ifdef BOOT_CHECKSUM_EN
          ld_state_d = LD_CHECK;
`else
          ld_state_d = LD_DONE;
          done_d     = 1'b1;
          cpu_hold_d = 1'b0;
`endif
        end else begin
          ld_state_d = LD_DATA;
        end
      end
`ifdef BOOT_CHECKSUM_EN
      LD_CHECK: begin
        if (byte_valid_q) begin
          byte_idx_d = byte_idx_q + 1'b1;
          acc_d      = {shift_q, acc_q[23:8]};
          if (byte_idx_q == 2'd3) begin
            if (full_word == sum_q) begin
              ld_state_d = LD_DONE;
              done_d     = 1'b1;
              cpu_hold_d = 1'b0;
            end else begin
              ld_state_d = LD_ERROR;
              error_d    = 1'b1;
            end
          end
        end
      end
`endif
      default: ;
    endcase
    // A corrupted byte poisons the image anywhere before completion.
    if (frame_err_q && ld_state_q != LD_DONE && ld_state_q != LD_ERROR) begin
      ld_state_d  = LD_ERROR;
      error_d     = 1'b1;
      mem_write_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q     <= 1'b1;
      rx_sync_q     <= 1'b1;
      rx_state_q    <= RX_IDLE;
      clk_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      byte_valid_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      ld_state_q    <= LD_COUNT;
      byte_idx_q    <= '0;
      acc_q         <= '0;
      words_left_q  <= '0;
      mem_address_q <= BASE_ADDR;
      mem_data_q    <= '0;
      mem_write_q   <= 1'b0;
      cpu_hold_q    <= 1'b1;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum_q         <= '0;
`endif
    end else begin
      rx_meta_q     <= rx;
      rx_sync_q     <= rx_meta_q;
      rx_state_q    <= rx_state_d;
      clk_cnt_q     <= clk_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      byte_valid_q  <= byte_valid_d;
      frame_err_q   <= frame_err_d;
      ld_state_q    <= ld_state_d;
      byte_idx_q    <= byte_idx_d;
      acc_q         <= acc_d;
      words_left_q  <= words_left_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      mem_write_q   <= mem_write_d;
      cpu_hold_q    <= cpu_hold_d;
      done_q        <= done_d;
      error_q       <= error_d;
`ifdef BOOT_CHECKSUM_EN
      sum_q         <= sum_d;
`endif
    end
  end

  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
  assign mem_write   = mem_write_q;
  assign cpu_hold    = cpu_hold_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: two instances (base 0x0 and 0x100) share one serial stream.
// Loads that need a checksum append it when BOOT_CHECKSUM_EN is defined.
module tb_uart_boot_loader;

  localparam int CPB = 4;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        rx    = 1'b1;
  logic [31:0] a_addr, a_data, b_addr, b_data;
  logic        a_wr, a_hold, a_done, a_err;
  logic        b_wr, b_hold, b_done, b_err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int a_wr_n = 0, b_wr_n = 0, back_to_back = 0;
  int a_last_wr_cyc = 0, a_done_cyc = 0;
  logic [31:0] a_log_addr [64];
  logic [31:0] a_log_data [64];
  logic [31:0] b_log_addr [64];
  logic [31:0] b_log_data [64];
  logic a_wr_prev = 1'b0, b_wr_prev = 1'b0, a_done_prev = 1'b0;

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(32'h0000_0000), .MAX_WORDS(1024)) dut0 (
    .clk(clk), .reset(reset), .rx(rx),
    .mem_address(a_addr), .mem_data(a_data), .mem_write(a_wr),
    .cpu_hold(a_hold), .done(a_done), .error(a_err)
  );

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(32'h0000_0100), .MAX_WORDS(1024)) dut1 (
    .clk(clk), .reset(reset), .rx(rx),
    .mem_address(b_addr), .mem_data(b_data), .mem_write(b_wr),
    .cpu_hold(b_hold), .done(b_done), .error(b_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write log, sampled on the falling edge so every strobe is seen exactly once.
  always @(negedge clk) begin
    if (a_wr) begin
      a_log_addr[a_wr_n % 64] <= a_addr;
      a_log_data[a_wr_n % 64] <= a_data;
      a_wr_n        <= a_wr_n + 1;
      a_last_wr_cyc <= cyc;
    end
    if (b_wr) begin
      b_log_addr[b_wr_n % 64] <= b_addr;
      b_log_data[b_wr_n % 64] <= b_data;
      b_wr_n <= b_wr_n + 1;
    end
    if ((a_wr && a_wr_prev) || (b_wr && b_wr_prev)) back_to_back <= back_to_back + 1;
    if (a_done && !a_done_prev) a_done_cyc <= cyc;
    a_wr_prev   <= a_wr;
    b_wr_prev   <= b_wr;
    a_done_prev <= a_done;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One 8N1 frame followed by one idle bit; bad_stop drives the stop bit low.
  task automatic applyStimulus(input logic [7:0] b, input logic bad_stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = !bad_stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic sendWord(input logic [31:0] w);
    for (int i = 0; i < 4; i++) applyStimulus(w[8*i +: 8], 1'b0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  int na, nb;

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_addr_a", a_addr, 32'h0);
    checkOutput("rst_addr_b", b_addr, 32'h100);
    checkOutput("rst_data", a_data, 32'h0);
    checkOutput("rst_write", {31'd0, a_wr}, 32'd0);
    checkOutput("rst_hold", {31'd0, a_hold}, 32'd1);
    checkOutput("rst_done", {31'd0, a_done}, 32'd0);
    checkOutput("rst_error", {31'd0, a_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Reset in the middle of the second word's first byte.
    na = a_wr_n;
    sendWord(32'd3);
    sendWord(32'h1122_3344);
    repeat (4) @(negedge clk);
    checkOutput("mid_writes", a_wr_n - na, 1);
    checkOutput("mid_addr_pre", a_addr, 32'h4);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_addr_a", a_addr, 32'h0);
    checkOutput("mid_rst_addr_b", b_addr, 32'h100);
    checkOutput("mid_rst_data", a_data, 32'h0);
    checkOutput("mid_rst_hold", {31'd0, a_hold}, 32'd1);
    checkOutput("mid_rst_done", {31'd0, a_done}, 32'd0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // One word at base 0 (and 0x100 on the second instance).
    na = a_wr_n;
    nb = b_wr_n;
    sendWord(32'd1);
    sendWord(32'hDEAD_BEEF);
`ifdef BOOT_CHECKSUM_EN
    sendWord(32'hDEAD_BEEF);
`endif
    repeat (10) @(negedge clk);
    checkOutput("w1_count", a_wr_n - na, 1);
    checkOutput("w1_addr", a_log_addr[na % 64], 32'h0);
    checkOutput("w1_data", a_log_data[na % 64], 32'hDEAD_BEEF);
    checkOutput("w1_addr_b", b_log_addr[nb % 64], 32'h100);
    checkOutput("w1_done", {31'd0, a_done}, 32'd1);
    checkOutput("w1_hold", {31'd0, a_hold}, 32'd0);
    checkOutput("w1_error", {31'd0, a_err}, 32'd0);
`ifndef BOOT_CHECKSUM_EN
    checkOutput("w1_done_latency", a_done_cyc, a_last_wr_cyc + 1);
`endif

    // Three words, checked on the 0x100 instance.
    pulseReset();
    nb = b_wr_n;
    sendWord(32'd3);
    sendWord(32'h1122_3344);
    sendWord(32'hA5A5_0F0F);
    sendWord(32'h0000_0080);
`ifdef BOOT_CHECKSUM_EN
    sendWord(32'hB6C7_42D3);
`endif
    repeat (10) @(negedge clk);
    checkOutput("w3_count", b_wr_n - nb, 3);
    checkOutput("w3_addr0", b_log_addr[(nb + 0) % 64], 32'h100);
    checkOutput("w3_data0", b_log_data[(nb + 0) % 64], 32'h1122_3344);
    checkOutput("w3_addr1", b_log_addr[(nb + 1) % 64], 32'h104);
    checkOutput("w3_data1", b_log_data[(nb + 1) % 64], 32'hA5A5_0F0F);
    checkOutput("w3_addr2", b_log_addr[(nb + 2) % 64], 32'h108);
    checkOutput("w3_data2", b_log_data[(nb + 2) % 64], 32'h0000_0080);
    checkOutput("w3_done", {31'd0, b_done}, 32'd1);
    checkOutput("w3_hold", {31'd0, b_hold}, 32'd0);

    // Zero-length image.
    pulseReset();
    na = a_wr_n;
    sendWord(32'd0);
`ifdef BOOT_CHECKSUM_EN
    sendWord(32'd0);
`endif
    repeat (10) @(negedge clk);
    checkOutput("zero_writes", a_wr_n - na, 0);
    checkOutput("zero_done", {31'd0, a_done}, 32'd1);
    checkOutput("zero_hold", {31'd0, a_hold}, 32'd0);
    checkOutput("zero_error", {31'd0, a_err}, 32'd0);

    // Count one above MAX_WORDS.
    pulseReset();
    na = a_wr_n;
    sendWord(32'h0000_0401);
    repeat (10) @(negedge clk);
    checkOutput("big_error", {31'd0, a_err}, 32'd1);
    checkOutput("big_hold", {31'd0, a_hold}, 32'd1);
    checkOutput("big_done", {31'd0, a_done}, 32'd0);
    sendWord(32'd1);
    sendWord(32'h1234_5678);
    repeat (10) @(negedge clk);
    checkOutput("big_error_sticky", {31'd0, a_err}, 32'd1);
    checkOutput("big_writes", a_wr_n - na, 0);

    // Framing error on the second data byte.
    pulseReset();
    na = a_wr_n;
    sendWord(32'd1);
    applyStimulus(8'hAA, 1'b0);
    applyStimulus(8'hBB, 1'b1);
    applyStimulus(8'hCC, 1'b0);
    applyStimulus(8'hDD, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("frame_error", {31'd0, a_err}, 32'd1);
    checkOutput("frame_hold", {31'd0, a_hold}, 32'd1);
    checkOutput("frame_writes", a_wr_n - na, 0);

    // One-cycle idle glitch must not count as a byte.
    pulseReset();
    @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("glitch_error", {31'd0, a_err}, 32'd0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("glitch_3bytes_done", {31'd0, a_done}, 32'd0);
    applyStimulus(8'h00, 1'b0);
`ifdef BOOT_CHECKSUM_EN
    sendWord(32'd0);
`endif
    repeat (10) @(negedge clk);
    checkOutput("glitch_4bytes_done", {31'd0, a_done}, 32'd1);
    checkOutput("glitch_error_end", {31'd0, a_err}, 32'd0);

`ifdef BOOT_CHECKSUM_EN
    // Sum of 0x00000001 and 0xFFFFFFFF wraps to zero.
    pulseReset();
    sendWord(32'd2);
    sendWord(32'h0000_0001);
    sendWord(32'hFFFF_FFFF);
    repeat (10) @(negedge clk);
    checkOutput("cks_hold_pending", {31'd0, a_hold}, 32'd1);
    sendWord(32'h0000_0000);
    repeat (10) @(negedge clk);
    checkOutput("cks_good_done", {31'd0, a_done}, 32'd1);
    checkOutput("cks_good_error", {31'd0, a_err}, 32'd0);
    pulseReset();
    sendWord(32'd2);
    sendWord(32'h0000_0001);
    sendWord(32'hFFFF_FFFF);
    sendWord(32'h0000_0001);
    repeat (10) @(negedge clk);
    checkOutput("cks_bad_error", {31'd0, a_err}, 32'd1);
    checkOutput("cks_bad_hold", {31'd0, a_hold}, 32'd1);
`endif

    checkOutput("no_back_to_back_writes", back_to_back, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
